// File: rtl/puf_eval_controller.sv
// Multi-vote evaluation controller for a parallel PUF array: runs VOTES settle/run
// cycles per request, majority-votes each response bit and reports stability or timeout.
module puf_eval_controller #(
  parameter int CHANNELS = 8,
  parameter int CHAL_W   = 8,
  parameter int EN_W     = 32,
  parameter int VOTES    = 5,
  parameter int SETTLE   = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clock,
  input  logic                computer_reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CHAL_W-1:0]   req_challenge,
  input  logic [EN_W-1:0]     req_enable,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [CHANNELS-1:0] rsp_data,
  output logic [CHANNELS-1:0] rsp_stable,
  output logic                rsp_timeout,
  output logic                puf_reset,
  output logic [EN_W-1:0]     puf_enable,
  output logic [CHAL_W-1:0]   puf_challenge,
  input  logic [CHANNELS-1:0] puf_out,
  input  logic [CHANNELS-1:0] puf_done
);

  localparam int CW = $clog2(VOTES + 1);
  localparam int TW = $clog2(TIMEOUT + SETTLE + 1);
  localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] VOTES_C      = CW'(VOTES);
  localparam logic [CW-1:0] HALF_C       = CW'(VOTES / 2);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SAMPLE,
    RESP
  } state_t;

  state_t state, next_state;

  logic [CHANNELS-1:0] out_s1, out_s2, done_s1, done_s2;
  logic                all_done;
  logic [TW-1:0]       timer;
  logic [CW-1:0]       eval_idx;
  logic [CW-1:0]       vote_cnt [CHANNELS];
  logic [EN_W-1:0]     enable_lat;
  logic                timed_out;
  logic                ready_en;
  logic                accept;
  logic                run_timeout;
  logic                last_eval;
  logic [CHANNELS-1:0] voted, unanimous;

  // The array is asynchronous to us; both response and done go through two flops.
  always_ff @(posedge clock) begin
    if (!computer_reset_n) begin
      out_s1  <= '0;
      out_s2  <= '0;
      done_s1 <= '0;
      done_s2 <= '0;
    end else begin
      out_s1  <= puf_out;
      out_s2  <= out_s1;
      done_s1 <= puf_done;
      done_s2 <= done_s1;
    end
  end

  assign all_done    = &done_s2;
  assign req_ready   = (state == IDLE) && ready_en;
  assign accept      = req_valid && req_ready;
  assign run_timeout = (state == RUN) && !all_done && (timer == TIMEOUT_LAST);
  assign last_eval   = ((eval_idx + CW'(1)) == VOTES_C);

  always_comb begin
    voted     = '0;
    unanimous = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      voted[i]     = vote_cnt[i] > HALF_C;
      unanimous[i] = (vote_cnt[i] == '0) || (vote_cnt[i] == VOTES_C);
    end
  end

  always_ff @(posedge clock) begin
    if (!computer_reset_n) state <= IDLE;
    else                   state <= next_state;
  end

  // Done is checked before timeout so a late-but-complete evaluation still counts.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = CLEAR;
      CLEAR:   if (timer == SETTLE_LAST) next_state = RUN;
      RUN: begin
        if (all_done)                   next_state = SAMPLE;
        else if (timer == TIMEOUT_LAST) next_state = RESP;
      end
      SAMPLE:  next_state = last_eval ? RESP : CLEAR;
      RESP:    if (rsp_valid && rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!computer_reset_n) begin
      ready_en      <= 1'b0;
      timer         <= '0;
      eval_idx      <= '0;
      enable_lat    <= '0;
      timed_out     <= 1'b0;
      puf_reset     <= 1'b1;
      puf_enable    <= '0;
      puf_challenge <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_stable    <= '0;
      rsp_timeout   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) vote_cnt[i] <= '0;
    end else begin
      ready_en   <= 1'b1;
      puf_reset  <= (next_state != RUN);
      puf_enable <= (next_state == RUN) ? enable_lat : '0;

      if ((state != next_state) || !((state == CLEAR) || (state == RUN)))
        timer <= '0;
      else
        timer <= timer + TW'(1);

      if (accept) begin
        puf_challenge <= req_challenge;
        enable_lat    <= req_enable;
        eval_idx      <= '0;
        timed_out     <= 1'b0;
        for (int i = 0; i < CHANNELS; i++) vote_cnt[i] <= '0;
      end

      if (state == SAMPLE) begin
        eval_idx <= eval_idx + CW'(1);
        for (int i = 0; i < CHANNELS; i++)
          if (out_s2[i] && (vote_cnt[i] != VOTES_C))
            vote_cnt[i] <= vote_cnt[i] + CW'(1);
      end

      if (run_timeout) timed_out <= 1'b1;

      // Response is loaded once on the first RESP cycle and then frozen until taken.
      if (state == RESP) begin
        if (!rsp_valid) begin
          rsp_valid   <= 1'b1;
          rsp_data    <= timed_out ? '0 : voted;
          rsp_stable  <= timed_out ? '0 : unanimous;
          rsp_timeout <= timed_out;
        end else if (rsp_ready) begin
          rsp_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_puf_eval_controller.sv
// Directed bench for puf_eval_controller with a behavioural PUF array model
// and a queue of expected responses checked when each response appears.
module tb_puf_eval_controller;

  localparam int VOTES   = 5;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        computer_reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_challenge = '0;
  logic [31:0] req_enable = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic [7:0]  rsp_stable;
  logic        rsp_timeout;
  logic        puf_reset;
  logic [31:0] puf_enable;
  logic [7:0]  puf_challenge;
  logic [7:0]  puf_out = '0;
  logic [7:0]  puf_done = '0;

  puf_eval_controller #(
    .CHANNELS(8), .CHAL_W(8), .EN_W(32),
    .VOTES(VOTES), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .computer_reset_n(computer_reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_challenge(req_challenge), .req_enable(req_enable),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_stable(rsp_stable), .rsp_timeout(rsp_timeout),
    .puf_reset(puf_reset), .puf_enable(puf_enable), .puf_challenge(puf_challenge),
    .puf_out(puf_out), .puf_done(puf_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic [7:0] stable;
    logic       to;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Array model knobs, written only by the stimulus block.
  logic [7:0] pattern [VOTES];
  int         done_delay = 3;
  logic [7:0] done_mask  = 8'hFF;
  int         base = 0;

  // Array model: new response at each puf_reset fall, done after done_delay cycles.
  int   fall_count = 0;
  int   run_cyc = 0;
  logic prev_reset = 1'b1;
  always @(negedge clock) begin
    if (puf_reset === 1'b0) begin
      if (prev_reset) begin
        if ((fall_count - base) >= 0 && (fall_count - base) < VOTES)
          puf_out = pattern[fall_count - base];
        else
          puf_out = 8'h00;
        fall_count = fall_count + 1;
      end
      run_cyc = run_cyc + 1;
    end else begin
      run_cyc = 0;
    end
    prev_reset = (puf_reset !== 1'b0);
    puf_done = ((puf_reset === 1'b0) && (run_cyc >= done_delay)) ? done_mask : 8'h00;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] chal, input logic [31:0] en);
    int n;
    @(negedge clock);
    base = fall_count;
    req_challenge = chal;
    req_enable = en;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) checkOutput("req_ready_wait", {31'b0, req_ready}, 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic awaitResponse(input logic [7:0] chal, input logic [31:0] en, input int hold);
    int   lat;
    bit   seen_run;
    exp_t e;
    lat = 0;
    seen_run = 0;
    while (rsp_valid !== 1'b1 && lat < 400) begin
      @(posedge clock);
      #1 lat++;
      if (puf_reset === 1'b0 && !seen_run) begin
        seen_run = 1;
        checkOutput("run_enable", puf_enable, en);
        checkOutput("run_challenge", {24'b0, puf_challenge}, {24'b0, chal});
      end
    end
    checkOutput("rsp_valid_seen", {31'b0, rsp_valid}, 32'd1);
    if (sb.size() == 0) begin
      checkOutput("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput("latency", lat, e.lat);
    checkOutput("rsp_data", {24'b0, rsp_data}, {24'b0, e.data});
    checkOutput("rsp_stable", {24'b0, rsp_stable}, {24'b0, e.stable});
    checkOutput("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.to});
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      req_valid = (k < hold - 1);
      req_challenge = chal ^ 8'hFF;
      @(posedge clock);
      #1;
      checkOutput("bp_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("bp_data", {24'b0, rsp_data}, {24'b0, e.data});
      checkOutput("bp_stable", {24'b0, rsp_stable}, {24'b0, e.stable});
      checkOutput("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    @(negedge clock);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("hs_valid_drop", {31'b0, rsp_valid}, 32'd0);
    checkOutput("hs_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("hs_challenge_kept", {24'b0, puf_challenge}, {24'b0, chal});
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic set_patterns(input logic [7:0] p0, p1, p2, p3, p4);
    pattern[0] = p0; pattern[1] = p1; pattern[2] = p2; pattern[3] = p3; pattern[4] = p4;
  endtask

  initial begin
    int n;
    int seen;
    set_patterns(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_puf_reset", {31'b0, puf_reset}, 32'd1);
    checkOutput("rst_puf_enable", puf_enable, 32'd0);
    checkOutput("rst_challenge", {24'b0, puf_challenge}, 32'd0);
    checkOutput("rst_rsp_data", {24'b0, rsp_data}, 32'd0);
    checkOutput("rst_rsp_stable", {24'b0, rsp_stable}, 32'd0);
    checkOutput("rst_rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
    @(negedge clock);
    computer_reset_n = 1'b1;
    @(posedge clock);
    #1 checkOutput("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Unanimous 8'hA5 with back-pressure; R = done_delay + 2 per evaluation.
    set_patterns(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    done_delay = 3; done_mask = 8'hFF;
    applyStimulus(8'h5A, 32'hDEADBEEF);
    sb.push_back('{8'hA5, 8'hFF, 1'b0, VOTES * (SETTLE + 1 + 5) + 1});
    awaitResponse(8'h5A, 32'hDEADBEEF, 10);

    // Split votes: bit0 3/5, bit1 2/5.
    set_patterns(8'h03, 8'h03, 8'h01, 8'h00, 8'h00);
    applyStimulus(8'h11, 32'h0000FFFF);
    sb.push_back('{8'h01, 8'hFC, 1'b0, VOTES * (SETTLE + 1 + 5) + 1});
    awaitResponse(8'h11, 32'h0000FFFF, 0);

    // Channel 7 never finishes.
    done_mask = 8'h7F;
    applyStimulus(8'h22, 32'h12345678);
    sb.push_back('{8'h00, 8'h00, 1'b1, SETTLE + TIMEOUT + 1});
    awaitResponse(8'h22, 32'h12345678, 0);

    // Done seen on the last allowed RUN cycle: R = TIMEOUT.
    done_mask = 8'hFF; done_delay = TIMEOUT - 2;
    set_patterns(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C);
    applyStimulus(8'h33, 32'hA0A0A0A0);
    sb.push_back('{8'h3C, 8'hFF, 1'b0, VOTES * (SETTLE + 1 + TIMEOUT) + 1});
    awaitResponse(8'h33, 32'hA0A0A0A0, 0);

    // Abort during the third evaluation's RUN phase.
    done_delay = 3;
    applyStimulus(8'h44, 32'hFFFFFFFF);
    n = 0;
    while (!((fall_count - base) >= 3 && puf_reset === 1'b0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    checkOutput("abort_reached_eval2", {31'b0, puf_reset}, 32'd0);
    computer_reset_n = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("abort_puf_reset", {31'b0, puf_reset}, 32'd1);
    checkOutput("abort_puf_enable", puf_enable, 32'd0);
    checkOutput("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("abort_req_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clock);
    computer_reset_n = 1'b1;
    @(posedge clock);
    #1 checkOutput("abort_release_ready", {31'b0, req_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clock);
      #1 if (rsp_valid === 1'b1) seen++;
    end
    checkOutput("abort_no_response", seen, 32'd0);

    // Fresh request after abort must vote from zero.
    set_patterns(8'hF0, 8'hF0, 8'h0F, 8'hF0, 8'h0F);
    done_delay = 5;
    applyStimulus(8'h55, 32'h00000001);
    sb.push_back('{8'hF0, 8'h00, 1'b0, VOTES * (SETTLE + 1 + 7) + 1});
    awaitResponse(8'h55, 32'h00000001, 0);

    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
